// File: rtl/sram22_arbiter.sv
// Two-port round-robin arbiter in front of a single-port SRAM macro.
// Read data returns one cycle after the grant, steered to the port that issued the read.
module sram22_arbiter #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 11,
    parameter int unsigned WMASK_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rstb,

    input  logic                   a_valid,
    output logic                   a_ready,
    input  logic                   a_we,
    input  logic [WMASK_WIDTH-1:0] a_wmask,
    input  logic [ADDR_WIDTH-1:0]  a_addr,
    input  logic [DATA_WIDTH-1:0]  a_wdata,
    output logic                   a_rvalid,
    output logic [DATA_WIDTH-1:0]  a_rdata,

    input  logic                   b_valid,
    output logic                   b_ready,
    input  logic                   b_we,
    input  logic [WMASK_WIDTH-1:0] b_wmask,
    input  logic [ADDR_WIDTH-1:0]  b_addr,
    input  logic [DATA_WIDTH-1:0]  b_wdata,
    output logic                   b_rvalid,
    output logic [DATA_WIDTH-1:0]  b_rdata,

    output logic                   sram_rstb,
    output logic                   sram_ce,
    output logic                   sram_we,
    output logic [WMASK_WIDTH-1:0] sram_wmask,
    output logic [ADDR_WIDTH-1:0]  sram_addr,
    output logic [DATA_WIDTH-1:0]  sram_din,
    input  logic [DATA_WIDTH-1:0]  sram_dout
);

    logic rr_q,   rr_d;
    logic rd_a_q, rd_a_d;
    logic rd_b_q, rd_b_d;
    logic grant_a, grant_b;

    always_comb begin
        // Grants are gated by rstb so nothing reaches the macro while reset is held.
        grant_a = rstb & a_valid & (~b_valid | ~rr_q);
        grant_b = rstb & b_valid & (~a_valid |  rr_q);

        rr_d = rr_q;
        if (grant_a) begin
            rr_d = 1'b1;
        end else if (grant_b) begin
            rr_d = 1'b0;
        end

        rd_a_d = grant_a & ~a_we;
        rd_b_d = grant_b & ~b_we;

        sram_ce    = 1'b0;
        sram_we    = 1'b0;
        sram_wmask = '0;
        sram_addr  = '0;
        sram_din   = '0;
        if (grant_a) begin
            sram_ce    = 1'b1;
            sram_we    = a_we;
            sram_wmask = a_wmask;
            sram_addr  = a_addr;
            sram_din   = a_wdata;
        end else if (grant_b) begin
            sram_ce    = 1'b1;
            sram_we    = b_we;
            sram_wmask = b_wmask;
            sram_addr  = b_addr;
            sram_din   = b_wdata;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            rr_q   <= 1'b0;
            rd_a_q <= 1'b0;
            rd_b_q <= 1'b0;
        end else begin
            rr_q   <= rr_d;
            rd_a_q <= rd_a_d;
            rd_b_q <= rd_b_d;
        end
    end

    always_comb begin
        a_ready   = grant_a;
        b_ready   = grant_b;
        a_rvalid  = rd_a_q;
        b_rvalid  = rd_b_q;
        a_rdata   = rd_a_q ? sram_dout : '0;
        b_rdata   = rd_b_q ? sram_dout : '0;
        sram_rstb = rstb;
    end

endmodule

// File: doc/sram22_arbiter.md
SRAM22_ARBITER -- requirements
Module: sram22_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, data word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 11, word address width.
REQ-003 Parameter WMASK_WIDTH, default 4, byte-lane mask width; DATA_WIDTH/WMASK_WIDTH bits per lane.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  clock; all state updates on posedge.
REQ-006 rstb  in  1  reset bar; asynchronous, active-low.
REQ-007 a_valid, b_valid  in  1 each  requester A/B access request.
REQ-008 a_ready, b_ready  out  1 each  request accepted this cycle.
REQ-009 a_we, b_we  in  1 each  1 = write, 0 = read.
REQ-010 a_wmask, b_wmask  in  WMASK_WIDTH each  byte-lane write enables.
REQ-011 a_addr, b_addr  in  ADDR_WIDTH each  word address.
REQ-012 a_wdata, b_wdata  in  DATA_WIDTH each  write data.
REQ-013 a_rvalid, b_rvalid  out  1 each  read data valid, one-cycle pulse.
REQ-014 a_rdata, b_rdata  out  DATA_WIDTH each  read data.
REQ-015 sram_rstb  out  1  macro reset bar; equals rstb.
REQ-016 sram_ce, sram_we  out  1 each  macro chip and write enable.
REQ-017 sram_wmask, sram_addr, sram_din  out  WMASK_WIDTH / ADDR_WIDTH / DATA_WIDTH  macro request.
REQ-018 sram_dout  in  DATA_WIDTH  macro read data, registered inside macro on the posedge of the read.

Function
REQ-019 Exactly zero or one request SHALL be granted per cycle; grant is combinational from the valids and the round-robin pointer rr.
REQ-020 One valid only: grant that requester. Both valid: grant A if rr=0, B if rr=1.
REQ-021 rr SHALL update on posedge when a grant occurs: rr <= 1 after an A grant, 0 after a B grant; otherwise hold.
REQ-022 x_ready SHALL be 1 exactly when x is granted; x_ready never asserts while x_valid=0.
REQ-023 On a grant: sram_ce=1; sram_we, sram_wmask, sram_addr, sram_din equal the granted requester's fields in the same cycle.
REQ-024 No grant: sram_ce=0, sram_we=0, sram_wmask=0; sram_addr and sram_din don't-care, driven 0.
REQ-025 A write with wmask all-zero SHALL still be granted and issued unchanged; it consumes the slot.
REQ-026 A granted read in cycle N SHALL assert x_rvalid in cycle N+1 only, with x_rdata = sram_dout in N+1.
REQ-027 A registered 2-bit tag (rd_a, rd_b) SHALL record the owner of the read issued last cycle; it is cleared when no read is granted.
REQ-028 x_rdata SHALL equal sram_dout while x_rvalid=1 and 0 otherwise.
REQ-029 Back-to-back reads, alternating or same-port, SHALL sustain one per cycle; each rvalid follows its own grant by exactly one cycle.
REQ-030 Requests SHALL take effect in grant order; a read granted after a write to the same address returns the written data.
REQ-031 Responses have no backpressure; requesters always accept x_rvalid.
REQ-032 A request withdrawn before grant SHALL be dropped without side effect; rr does not change.

Reset
REQ-033 While rstb=0: rr=0, rd_a=rd_b=0, a_ready=b_ready=0, a_rvalid=b_rvalid=0, rdata=0, sram_ce=0, sram_we=0, sram_wmask=0.
REQ-034 Reset asserted mid-read SHALL discard the pending response; no rvalid follows deassertion.
REQ-035 First cycle after reset release with both valid SHALL grant A.

Verification
REQ-036 A writes addr 0x005 data 0xDEADBEEF wmask 4'hF, then reads 0x005 -> a_rvalid one cycle after read grant, a_rdata=0xDEADBEEF, b_rvalid stays 0.
REQ-037 Both valid continuously for 6 cycles -> grants A,B,A,B,A,B; sram_ce=1 every cycle.
REQ-038 B writes 0x7FF data 0x11223344 wmask 4'b0101 over prior 0xAABBCCDD -> B read returns 0xAA22CC44.
REQ-039 A reads 0x010 and B reads 0x020 in consecutive cycles -> a_rvalid then b_rvalid on successive cycles, each with its own data, never both high.
REQ-040 rstb low the cycle after an A read grant -> no a_rvalid at any later cycle; after release both valid -> A granted first.
